// File: rtl/nv_arb2_pipe.sv
// Two-input round-robin packet arbiter with one-entry output pipe and registered mux select.
// Latency: one cycle from accept to out_pvld. Backpressure: out_prdy=0 freezes the pipe and drops both prdy.
// Optional per-input beat counters with synchronous clear: define NV_ARB2_PIPE_BEAT_CNT_EN.
module nv_arb2_pipe #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             in0_pvld,
    output logic             in0_prdy,
    input  logic [DW-1:0]    in0_pd,
    input  logic             in0_last,
    input  logic             in1_pvld,
    output logic             in1_prdy,
    input  logic [DW-1:0]    in1_pd,
    input  logic             in1_last,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [DW-1:0]    out_pd,
    output logic             out_last,
`ifdef NV_ARB2_PIPE_BEAT_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
`endif
    output logic             mux_sel
);

    if (DW < 1 || CNT_W < 1) begin : g_bad_param
        $error("nv_arb2_pipe: DW and CNT_W must be at least 1");
    end

    logic          locked;
    logic          last_grant;
    logic          ld;
    logic          grant;
    logic          grant_vld;
    logic          acc;
    logic [DW-1:0] sel_pd;
    logic          sel_last;

    // A locked packet keeps its source; otherwise round-robin under contention.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (locked) begin
            grant_vld = 1'b1;
            grant     = mux_sel;
        end else if (in0_pvld && in1_pvld) begin
            grant_vld = 1'b1;
            grant     = ~last_grant;
        end else if (in0_pvld) begin
            grant_vld = 1'b1;
            grant     = 1'b0;
        end else if (in1_pvld) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
        end
    end

    assign ld       = ~out_pvld | out_prdy;
    assign in0_prdy = ld & grant_vld & ~grant & (locked | in0_pvld);
    assign in1_prdy = ld & grant_vld &  grant & (locked | in1_pvld);
    assign acc      = grant ? (in1_pvld & in1_prdy) : (in0_pvld & in0_prdy);
    assign sel_pd   = grant ? in1_pd   : in0_pd;
    assign sel_last = grant ? in1_last : in0_last;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            out_pvld   <= 1'b0;
            out_pd     <= '0;
            out_last   <= 1'b0;
            mux_sel    <= 1'b0;
            locked     <= 1'b0;
            last_grant <= 1'b1;
        end else if (acc) begin
            out_pvld   <= 1'b1;
            out_pd     <= sel_pd;
            out_last   <= sel_last;
            mux_sel    <= grant;
            last_grant <= grant;
            locked     <= ~sel_last;
        end else if (out_prdy) begin
            out_pvld   <= 1'b0;
        end
    end

`ifdef NV_ARB2_PIPE_BEAT_CNT_EN
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (acc) begin
            if (grant) cnt1 <= cnt1 + 1'b1;
            else       cnt0 <= cnt0 + 1'b1;
        end
    end
`endif

endmodule
